dewhiten_pdu_extract: RTL and testbench

DEWHITEN_PDU_EXTRACT -- requirements
Module: dewhiten_pdu_extract

---
 rtl/dewhiten_pdu_extract.sv | 190 +++++++++++++++++++
 tb/tb_dewhiten_pdu_extract.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dewhiten_pdu_extract.sv
// BLE link-layer receive path: dewhitens air bits, frames header/payload/CRC bytes.
// Define CRC_CHECK_EN to add the serial CRC-24 check that drives crc_ok.
module dewhiten_pdu_extract #(
  parameter int unsigned CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int unsigned MAX_PDU_LEN              = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
  input  logic                                start,
  input  logic                                bit_in,
  input  logic                                bit_in_valid,
  input  logic [23:0]                         crc_init,
  output logic [7:0]                          byte_out,
  output logic [1:0]                          byte_tag,
  output logic                                byte_out_valid,
  output logic [7:0]                          pdu_len,
  output logic                                busy,
  output logic                                pdu_done,
  output logic                                len_error,
  output logic                                crc_ok
);

  localparam int unsigned CntMax = (MAX_PDU_LEN + 5) * 8;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StHeader, StPayload, StCrc} state_e;

  state_e          state_q, state_d;
  logic [6:0]      lfsr_q, lfsr_d, lfsr_load, lfsr_step;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc, pay_end, crc_end;
  logic [7:0]      sr_q, sr_d, byte_nxt;
  logic [7:0]      byte_q, byte_d, len_q, len_d;
  logic [1:0]      tag_q, tag_d;
  logic            valid_q, valid_d, done_q, done_d, lerr_q, lerr_d;
  logic [5:0]      ch6;
  logic            accept, d_bit, crc_last;

  assign ch6       = 6'(channel_number);
  // lfsr[0] = 1, lfsr[1..6] = channel bits 5..0
  assign lfsr_load = {ch6[0], ch6[1], ch6[2], ch6[3], ch6[4], ch6[5], 1'b1};
  assign lfsr_step = {lfsr_q[5], lfsr_q[4], lfsr_q[3] ^ lfsr_q[6], lfsr_q[2], lfsr_q[1],
                      lfsr_q[0], lfsr_q[6]};

  assign accept   = bit_in_valid && (state_q != StIdle);
  assign d_bit    = lfsr_q[6] ^ bit_in;
  assign byte_nxt = {d_bit, sr_q[7:1]};
  assign cnt_inc  = cnt_q + CntW'(1);
  assign pay_end  = CntW'(16) + CntW'({len_q, 3'b000});
  assign crc_end  = pay_end + CntW'(24);
  assign crc_last = (state_q == StCrc) && (cnt_inc == crc_end);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    byte_d  = byte_q;
    tag_d   = tag_q;
    len_d   = len_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    lerr_d  = 1'b0;
    if (start) begin
      state_d = StHeader;
      lfsr_d  = lfsr_load;
      cnt_d   = '0;
      sr_d    = '0;
      len_d   = '0;
    end else if (accept) begin
      lfsr_d = lfsr_step;
      cnt_d  = cnt_inc;
      sr_d   = byte_nxt;
      // every field is byte aligned, so byte completion is just the low counter bits
      if (cnt_q[2:0] == 3'b111) begin
        byte_d  = byte_nxt;
        valid_d = 1'b1;
        unique case (state_q)
          StHeader:  tag_d = 2'd0;
          StPayload: tag_d = 2'd1;
          default:   tag_d = 2'd2;
        endcase
      end
      unique case (state_q)
        StHeader: begin
          if (cnt_q == CntW'(15)) begin
            len_d = byte_nxt;
            if ({24'b0, byte_nxt} > MAX_PDU_LEN) begin
              state_d = StIdle;
              lerr_d  = 1'b1;
            end else if (byte_nxt == 8'd0) begin
              state_d = StCrc;
            end else begin
              state_d = StPayload;
            end
          end
        end
        StPayload: if (cnt_inc == pay_end) state_d = StCrc;
        StCrc: begin
          if (crc_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= lfsr_load;
      cnt_q   <= '0;
      sr_q    <= '0;
      byte_q  <= '0;
      tag_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      byte_q  <= byte_d;
      tag_q   <= tag_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      lerr_q  <= lerr_d;
    end
  end

  assign byte_out       = byte_q;
  assign byte_tag       = tag_q;
  assign byte_out_valid = valid_q;
  assign pdu_len        = len_q;
  assign busy           = (state_q != StIdle);
  assign pdu_done       = done_q;
  assign len_error      = lerr_q;

`ifdef CRC_CHECK_EN
  logic [23:0] crc_q, crc_d;
  logic        bad_q, bad_d, ok_q, ok_d, crc_fb, bad_nxt;

  assign crc_fb  = crc_q[23] ^ d_bit;
  assign bad_nxt = bad_q | crc_fb;

  // Header/payload bits advance the CRC; CRC bits are compared against its MSB in air order.
  always_comb begin
    crc_d = crc_q;
    bad_d = bad_q;
    ok_d  = ok_q;
    if (start) begin
      crc_d = crc_init;
      bad_d = 1'b0;
      ok_d  = 1'b0;
    end else if (accept) begin
      if (state_q == StCrc) begin
        crc_d = {crc_q[22:0], 1'b0};
        bad_d = bad_nxt;
        if (crc_last) ok_d = ~bad_nxt;
      end else begin
        crc_d = {crc_q[22:0], 1'b0} ^ (crc_fb ? 24'h00065B : 24'h000000);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= '0;
      bad_q <= 1'b0;
      ok_q  <= 1'b0;
    end else begin
      crc_q <= crc_d;
      bad_q <= bad_d;
      ok_q  <= ok_d;
    end
  end

  assign crc_ok = ok_q;
`else
  logic crc_init_unused;
  assign crc_init_unused = ^crc_init;
  assign crc_ok          = 1'b0;
`endif

endmodule

// File: tb/tb_dewhiten_pdu_extract.sv
// Directed bench for dewhiten_pdu_extract: builds whitened packets with a reference model.
module tb_dewhiten_pdu_extract;

  localparam int unsigned MaxLen = 37;

  logic       clk = 1'b0;
  logic       rst, start, bit_in, bit_in_valid;
  logic [5:0] channel_number;
  logic [23:0] crc_init;
  logic [7:0] byte_out, pdu_len;
  logic [1:0] byte_tag;
  logic       byte_out_valid, busy, pdu_done, len_error, crc_ok;

  always #5 clk = ~clk;

  dewhiten_pdu_extract #(
    .CHANNEL_NUMBER_BIT_WIDTH(6),
    .MAX_PDU_LEN(MaxLen)
  ) dut (
    .clk(clk),
    .rst(rst),
    .channel_number(channel_number),
    .start(start),
    .bit_in(bit_in),
    .bit_in_valid(bit_in_valid),
    .crc_init(crc_init),
    .byte_out(byte_out),
    .byte_tag(byte_tag),
    .byte_out_valid(byte_out_valid),
    .pdu_len(pdu_len),
    .busy(busy),
    .pdu_done(pdu_done),
    .len_error(len_error),
    .crc_ok(crc_ok)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit         plain_q[$];
  bit         air_q[$];
  logic [7:0] exp_byte[$];
  logic [1:0] exp_tag[$];
  logic       exp_crc_ok;

  logic [7:0] obs_byte[$];
  logic [1:0] obs_tag[$];
  logic       obs_done[$];
  int         obs_cyc[$];
  int         bit_cyc[$];
  int         n_done, n_lerr, lerr_cyc;
  logic       busy_after_lerr;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (byte_out_valid === 1'b1) begin
      obs_byte.push_back(byte_out);
      obs_tag.push_back(byte_tag);
      obs_done.push_back(pdu_done);
      obs_cyc.push_back(cyc);
    end
    if (pdu_done === 1'b1) n_done++;
    if (len_error === 1'b1) begin
      n_lerr++;
      lerr_cyc = cyc;
    end
    if (cyc == lerr_cyc + 1) busy_after_lerr = busy;
  endtask

  task automatic clear_obs();
    obs_byte.delete();
    obs_tag.delete();
    obs_done.delete();
    obs_cyc.delete();
    n_done          = 0;
    n_lerr          = 0;
    lerr_cyc        = -100;
    busy_after_lerr = 1'bx;
  endtask

  // Plain bits = header, payload, CRC (MSB first); air bits = plain xor whitening sequence.
  task automatic build_packet(input logic [5:0] ch, input logic [7:0] hdr0, input logic [7:0] len,
                              input logic [7:0] seed, input logic [23:0] init, input int flip);
    logic [7:0]  b;
    logic [23:0] c;
    logic [6:0]  w, nw;
    logic        fb;
    int          nbytes;
    plain_q.delete();
    air_q.delete();
    exp_byte.delete();
    exp_tag.delete();
    for (int i = 0; i < 2 + int'(len); i++) begin
      if (i == 0) b = hdr0;
      else if (i == 1) b = len;
      else b = seed + 8'(i * 29);
      for (int k = 0; k < 8; k++) plain_q.push_back(b[k]);
    end
    c = init;
    for (int i = 0; i < plain_q.size(); i++) begin
      fb = c[23] ^ plain_q[i];
      c  = {c[22:0], 1'b0};
      if (fb) c = c ^ 24'h00065B;
    end
    for (int k = 23; k >= 0; k--) plain_q.push_back(c[k]);
    if (flip >= 0) plain_q[plain_q.size() - 24 + flip] = !plain_q[plain_q.size() - 24 + flip];
    w[0] = 1'b1;
    for (int k = 1; k <= 6; k++) w[k] = ch[6 - k];
    for (int i = 0; i < plain_q.size(); i++) begin
      air_q.push_back(plain_q[i] ^ w[6]);
      nw    = {w[5:0], w[6]};
      nw[4] = w[3] ^ w[6];
      w     = nw;
    end
    nbytes = plain_q.size() / 8;
    for (int j = 0; j < nbytes; j++) begin
      for (int k = 0; k < 8; k++) b[k] = plain_q[8 * j + k];
      exp_byte.push_back(b);
      exp_tag.push_back(j < 2 ? 2'd0 : (j < 2 + int'(len) ? 2'd1 : 2'd2));
    end
`ifdef CRC_CHECK_EN
    exp_crc_ok = (flip < 0);
`else
    exp_crc_ok = 1'b0;
`endif
  endtask

  task automatic do_start(input logic [5:0] ch, input logic [23:0] init);
    channel_number = ch;
    crc_init       = init;
    start          = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bits(input int gap, input int count);
    bit_cyc.delete();
    for (int i = 0; i < count; i++) begin
      if (gap != 0) begin
        bit_in_valid = 1'b0;
        bit_in       = 1'($urandom_range(0, 1));
        tick();
      end
      bit_in_valid = 1'b1;
      bit_in       = air_q[i];
      tick();
      bit_cyc.push_back(cyc);
    end
    bit_in_valid = 1'b0;
    bit_in       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; channel_number = 6'd37; crc_init = 24'h0;
    start = 1'b0; bit_in_valid = 1'b0; bit_in = 1'b0;
    clear_obs();
    tick();
    start = 1'b1; bit_in_valid = 1'b1; bit_in = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; bit_in_valid = 1'b0;
    total++; if (byte_out !== 8'h00) begin bad++; $display("FAIL rst_byte_out got=%h want=00", byte_out); end
    total++; if (byte_tag !== 2'd0) begin bad++; $display("FAIL rst_byte_tag got=%0d want=0", byte_tag); end
    total++; if (byte_out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", byte_out_valid); end
    total++; if (pdu_len !== 8'h00) begin bad++; $display("FAIL rst_pdu_len got=%h want=00", pdu_len); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (pdu_done !== 1'b0) begin bad++; $display("FAIL rst_pdu_done got=%b want=0", pdu_done); end
    total++; if (len_error !== 1'b0) begin bad++; $display("FAIL rst_len_error got=%b want=0", len_error); end
    total++; if (crc_ok !== 1'b0) begin bad++; $display("FAIL rst_crc_ok got=%b want=0", crc_ok); end
    clear_obs();
    bit_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bit_in = 1'(i % 3 == 0);
      tick();
    end
    bit_in_valid = 1'b0;
    tick();
    total++; if (obs_byte.size() != 0) begin bad++; $display("FAIL idle_strobes got=%0d want=0", obs_byte.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  // Shared by the full-packet scenarios: compare one decoded packet against the model.
  task automatic test_packet(input string name, input logic [5:0] ch, input logic [7:0] hdr0,
                             input logic [7:0] len, input logic [23:0] init, input int flip,
                             input int gap);
    build_packet(ch, hdr0, len, 8'h5A ^ 8'(ch), init, flip);
    clear_obs();
    do_start(ch, init);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_start got=%b want=1", name, busy); end
    send_bits(gap, air_q.size());
    repeat (3) tick();
    total++;
    if (obs_byte.size() != exp_byte.size()) begin
      bad++; $display("FAIL %s byte_count got=%0d want=%0d", name, obs_byte.size(), exp_byte.size());
    end
    for (int j = 0; j < obs_byte.size() && j < exp_byte.size(); j++) begin
      total++;
      if (obs_byte[j] !== exp_byte[j] || obs_tag[j] !== exp_tag[j]) begin
        bad++;
        $display("FAIL %s byte%0d got=%h/%0d want=%h/%0d", name, j, obs_byte[j], obs_tag[j],
                 exp_byte[j], exp_tag[j]);
      end
      total++;
      if (obs_cyc[j] != bit_cyc[8 * j + 7]) begin
        bad++; $display("FAIL %s strobe_cyc%0d got=%0d want=%0d", name, j, obs_cyc[j], bit_cyc[8 * j + 7]);
      end
      total++;
      if (obs_done[j] !== (j == exp_byte.size() - 1)) begin
        bad++; $display("FAIL %s done_at%0d got=%b want=%b", name, j, obs_done[j], j == exp_byte.size() - 1);
      end
    end
    total++; if (n_done != 1) begin bad++; $display("FAIL %s done_count got=%0d want=1", name, n_done); end
    total++; if (n_lerr != 0) begin bad++; $display("FAIL %s len_error_count got=%0d want=0", name, n_lerr); end
    total++; if (pdu_len !== len) begin bad++; $display("FAIL %s pdu_len got=%h want=%h", name, pdu_len, len); end
    total++; if (crc_ok !== exp_crc_ok) begin bad++; $display("FAIL %s crc_ok got=%b want=%b", name, crc_ok, exp_crc_ok); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_end got=%b want=0", name, busy); end
  endtask

  task automatic test_empty_pdu();
    test_packet("empty_pdu", 6'd37, 8'h02, 8'd0, 24'h555555, -1, 0);
  endtask

  task automatic test_payload_gapped();
    test_packet("payload_gapped", 6'd0, 8'h02, 8'd6, 24'h123456, -1, 1);
  endtask

  task automatic test_corrupt_crc();
    test_packet("corrupt_crc", 6'd12, 8'h06, 8'd3, 24'h555555, 5, 0);
  endtask

  task automatic test_max_len();
    test_packet("max_len", 6'd39, 8'h0E, 8'(MaxLen), 24'hABCDEF, -1, 0);
  endtask

  task automatic test_len_error();
    build_packet(6'd5, 8'h01, 8'd38, 8'h11, 24'h555555, -1);
    clear_obs();
    do_start(6'd5, 24'h555555);
    send_bits(0, 48);
    repeat (3) tick();
    total++; if (n_lerr != 1) begin bad++; $display("FAIL len_err_count got=%0d want=1", n_lerr); end
    total++; if (obs_byte.size() != 2) begin bad++; $display("FAIL len_err_bytes got=%0d want=2", obs_byte.size()); end
    for (int j = 0; j < obs_byte.size(); j++) begin
      total++;
      if (obs_tag[j] !== 2'd0 || obs_byte[j] !== exp_byte[j]) begin
        bad++; $display("FAIL len_err_byte%0d got=%h/%0d want=%h/0", j, obs_byte[j], obs_tag[j], exp_byte[j]);
      end
    end
    total++; if (n_done != 0) begin bad++; $display("FAIL len_err_done got=%0d want=0", n_done); end
    total++; if (busy_after_lerr !== 1'b0) begin bad++; $display("FAIL len_err_busy got=%b want=0", busy_after_lerr); end
    total++; if (pdu_len !== 8'd38) begin bad++; $display("FAIL len_err_pdu_len got=%h want=26", pdu_len); end
  endtask

  task automatic test_back_to_back_restart();
    build_packet(6'd20, 8'h01, 8'd5, 8'h33, 24'h0A0B0C, -1);
    clear_obs();
    do_start(6'd20, 24'h0A0B0C);
    send_bits(0, 35);
    total++; if (obs_byte.size() != 4) begin bad++; $display("FAIL restart_a_bytes got=%0d want=4", obs_byte.size()); end
    total++; if (n_done != 0) begin bad++; $display("FAIL restart_a_done got=%0d want=0", n_done); end
    build_packet(6'd9, 8'h02, 8'd2, 8'h71, 24'h555555, -1);
    clear_obs();
    channel_number = 6'd9;
    crc_init       = 24'h555555;
    start          = 1'b1;
    bit_in_valid   = 1'b1;
    bit_in         = 1'b1;
    tick();
    start        = 1'b0;
    bit_in_valid = 1'b0;
    total++; if (obs_byte.size() != 0) begin bad++; $display("FAIL restart_partial got=%0d want=0", obs_byte.size()); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%b want=1", busy); end
    send_bits(0, air_q.size());
    repeat (3) tick();
    total++;
    if (obs_byte.size() != exp_byte.size()) begin
      bad++; $display("FAIL restart_b_count got=%0d want=%0d", obs_byte.size(), exp_byte.size());
    end
    for (int j = 0; j < obs_byte.size() && j < exp_byte.size(); j++) begin
      total++;
      if (obs_byte[j] !== exp_byte[j] || obs_tag[j] !== exp_tag[j]) begin
        bad++;
        $display("FAIL restart_b_byte%0d got=%h/%0d want=%h/%0d", j, obs_byte[j], obs_tag[j],
                 exp_byte[j], exp_tag[j]);
      end
    end
    total++; if (n_done != 1) begin bad++; $display("FAIL restart_done got=%0d want=1", n_done); end
    total++; if (crc_ok !== exp_crc_ok) begin bad++; $display("FAIL restart_crc_ok got=%b want=%b", crc_ok, exp_crc_ok); end
  endtask

  initial begin
    test_reset();
    test_empty_pdu();
    test_payload_gapped();
    test_corrupt_crc();
    test_max_len();
    test_len_error();
    test_back_to_back_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
